// File: rtl/ysyx_22040365_ctrl_if.sv
// Handshake bundle between the sequencer, instruction memory and the id/ex/regfile datapath.
// Latency: none, wires only.
// Backpressure: imem_req held until imem_ack; EXEC waits on ex_done.
interface ysyx_22040365_ctrl_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        ex_start;
    logic        ex_done;
    logic        jump;
    logic [63:0] jump_target;
    logic        halt_req;
    logic        wen_rd;
    logic [63:0] pc;
    logic        halted;
    logic        err;
    logic [63:0] cycle_cnt;
    logic [63:0] instret;

    modport master (
        output imem_req, imem_addr, inst, inst_valid, ex_start, wen_rd,
               pc, halted, err, cycle_cnt, instret,
        input  imem_ack, imem_rdata, ex_done, jump, jump_target, halt_req
    );

    modport slave (
        input  imem_req, imem_addr, inst, inst_valid, ex_start, wen_rd,
               pc, halted, err, cycle_cnt, instret,
        output imem_ack, imem_rdata, ex_done, jump, jump_target, halt_req
    );
endinterface

// File: rtl/ysyx_22040365_ctrl.sv
// Multi-cycle sequencer: FETCH -> DECODE -> EXEC -> WB, with ebreak/timeout halt and counters.
// Latency: 4 cycles minimum per instruction (ack and ex_done both in their first cycle).
// Backpressure: FETCH stalls on imem_ack (bounded by TIMEOUT), EXEC stalls on ex_done.
module ysyx_22040365_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22040365_ctrl_if.master    bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        timeout_hit;
    logic [63:0] pc_q;
    logic [63:0] pc_nxt_q;
    logic [31:0] inst_q;
    logic [7:0]  wait_q;
    logic        ex_first_q;
    logic        halted_q;
    logic        err_q;
    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    // Next-state selection; ack beats a coincident timeout.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            S_FETCH: begin
                if (bus.imem_ack) begin
                    state_nxt = S_DECODE;
                end else if (wait_q == TIMEOUT) begin
                    state_nxt   = S_HALT;
                    timeout_hit = 1'b1;
                end
            end
            S_DECODE: state_nxt = bus.halt_req ? S_HALT : S_EXEC;
            S_EXEC:   if (bus.ex_done) state_nxt = S_WB;
            S_WB:     state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_HALT;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= state_nxt;
    end

    // Datapath registers: instruction latch, pc update, wait counter, sticky flags, counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pc_nxt_q   <= RESET_PC;
            inst_q     <= 32'd0;
            wait_q     <= 8'd0;
            ex_first_q <= 1'b0;
            halted_q   <= 1'b0;
            err_q      <= 1'b0;
            cycle_q    <= 64'd0;
            instret_q  <= 64'd0;
        end else begin
            // Counter is zero outside FETCH, so it starts from zero on every entry.
            wait_q <= (state == S_FETCH && !bus.imem_ack) ? wait_q + 8'd1 : 8'd0;
            if (state == S_FETCH && bus.imem_ack) inst_q <= bus.imem_rdata;
            // Bit 0 of a redirect is dropped; bit 1 passes through untouched.
            if (state == S_EXEC && bus.ex_done)
                pc_nxt_q <= bus.jump ? {bus.jump_target[63:1], 1'b0} : pc_q + 64'd4;
            if (state == S_WB) pc_q <= pc_nxt_q;
            // Marks exactly the first EXEC cycle so ex_start cannot re-pulse while waiting.
            ex_first_q <= (state == S_DECODE) && !bus.halt_req;
            if (state != S_HALT) cycle_q <= cycle_q + 64'd1;
            if (state == S_WB || (state == S_DECODE && bus.halt_req))
                instret_q <= instret_q + 64'd1;
            if (timeout_hit) err_q <= 1'b1;
            if (state_nxt == S_HALT && state != S_HALT) halted_q <= 1'b1;
        end
    end

    // imem_req is masked by rst so it reads 0 while reset is held.
    assign bus.imem_req   = (state == S_FETCH) && !rst;
    assign bus.imem_addr  = pc_q;
    assign bus.inst       = inst_q;
    assign bus.inst_valid = (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
    assign bus.ex_start   = (state == S_EXEC) && ex_first_q;
    assign bus.wen_rd     = (state == S_WB);
    assign bus.pc         = pc_q;
    assign bus.halted     = halted_q;
    assign bus.err        = err_q;
    assign bus.cycle_cnt  = cycle_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_ysyx_22040365_ctrl.sv
// Self-checking bench: acts as instruction memory and execute unit around the sequencer.
// Latency: reference tracks pc/instret/cycle counts per instruction from stall lengths.
// Backpressure: random fetch waits (0..TIMEOUT) and random execute delays.
module tb_ysyx_22040365_ctrl;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [7:0]  TMO      = 8'd4;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    // Reference state: pc of the next fetch, non-halted cycles elapsed, retired count.
    logic [63:0] m_pc;
    logic [63:0] m_cycles;
    logic [63:0] m_instret;

    ysyx_22040365_ctrl_if bus();

    ysyx_22040365_ctrl #(.RESET_PC(RESET_PC), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task idle_inputs;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = $urandom;
        bus.ex_done     = 1'b0;
        bus.jump        = 1'b0;
        bus.jump_target = 64'd0;
        bus.halt_req    = 1'b0;
    endtask

    task do_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        m_pc      = RESET_PC;
        m_cycles  = 64'd0;
        m_instret = 64'd0;
    endtask

    // One full instruction: wn FETCH wait cycles, en EXEC wait cycles.
    task run_instr(input int wn, input int en, input bit jmp, input logic [63:0] tgt,
                   input logic [31:0] word);
        int starts;
        int wens;
        starts = 0;
        wens   = 0;
        for (int k = 0; k <= wn; k++) begin
            tests_run++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== m_pc) begin
                tests_failed++;
                $display("FAIL fetch: req=%b addr=%h, want req=1 addr=%h", bus.imem_req, bus.imem_addr, m_pc);
            end
            if (k == 0) begin
                tests_run++;
                if (bus.cycle_cnt !== m_cycles || bus.instret !== m_instret) begin
                    tests_failed++;
                    $display("FAIL counters: cycle=%0d instret=%0d, want %0d %0d", bus.cycle_cnt, bus.instret, m_cycles, m_instret);
                end
            end
            if (bus.ex_start) starts++;
            if (bus.wen_rd) wens++;
            bus.imem_ack   = (k == wn);
            bus.imem_rdata = (k == wn) ? word : $urandom;
            @(negedge clk);
            m_cycles++;
        end
        bus.imem_ack = 1'b0;
        tests_run++;
        if (bus.inst !== word || bus.inst_valid !== 1'b1 || bus.pc !== m_pc || bus.imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL decode: inst=%h valid=%b pc=%h req=%b, want inst=%h valid=1 pc=%h req=0",
                     bus.inst, bus.inst_valid, bus.pc, bus.imem_req, word, m_pc);
        end
        if (bus.ex_start) starts++;
        if (bus.wen_rd) wens++;
        bus.halt_req = 1'b0;
        @(negedge clk);
        m_cycles++;
        for (int k = 0; k <= en; k++) begin
            tests_run++;
            if (bus.ex_start !== (k == 0)) begin
                tests_failed++;
                $display("FAIL ex_start: cycle %0d of exec got %b", k, bus.ex_start);
            end
            if (bus.ex_start) starts++;
            if (bus.wen_rd) wens++;
            bus.ex_done     = (k == en);
            bus.jump        = (k == en) ? jmp : 1'($urandom);
            bus.jump_target = (k == en) ? tgt : {$urandom, $urandom};
            @(negedge clk);
            m_cycles++;
        end
        bus.ex_done = 1'b0;
        bus.jump    = 1'b0;
        tests_run++;
        if (bus.wen_rd !== 1'b1 || bus.instret !== m_instret || bus.inst_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL writeback: wen=%b instret=%0d valid=%b, want wen=1 instret=%0d valid=1",
                     bus.wen_rd, bus.instret, bus.inst_valid, m_instret);
        end
        if (bus.ex_start) starts++;
        if (bus.wen_rd) wens++;
        @(negedge clk);
        m_cycles++;
        m_instret++;
        m_pc = jmp ? {tgt[63:1], 1'b0} : m_pc + 64'd4;
        tests_run++;
        if (starts != 1 || wens != 1) begin
            tests_failed++;
            $display("FAIL pulses: ex_start=%0d wen_rd=%0d, want 1 and 1", starts, wens);
        end
    endtask

    task test_reset;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.imem_req !== 1'b0 || bus.pc !== RESET_PC || bus.inst !== 32'd0 || bus.inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fetch: req=%b pc=%h inst=%h valid=%b", bus.imem_req, bus.pc, bus.inst, bus.inst_valid);
        end
        tests_run++;
        if (bus.ex_start !== 1'b0 || bus.wen_rd !== 1'b0 || bus.halted !== 1'b0 || bus.err !== 1'b0 ||
            bus.cycle_cnt !== 64'd0 || bus.instret !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_flags: start=%b wen=%b halted=%b err=%b cyc=%0d ret=%0d, want all 0",
                     bus.ex_start, bus.wen_rd, bus.halted, bus.err, bus.cycle_cnt, bus.instret);
        end
        rst = 1'b0;
        #1;
        m_pc      = RESET_PC;
        m_cycles  = 64'd0;
        m_instret = 64'd0;
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            tests_failed++;
            $display("FAIL reset_release: req=%b addr=%h, want 1 %h", bus.imem_req, bus.imem_addr, RESET_PC);
        end
    endtask

    task test_straight_line;
        do_reset();
        repeat (3) run_instr(0, 0, 1'b0, 64'd0, $urandom);
        tests_run++;
        if (bus.cycle_cnt !== 64'd12 || bus.instret !== 64'd3 || bus.imem_addr !== 64'h8000_000C) begin
            tests_failed++;
            $display("FAIL straight_line: cycle=%0d instret=%0d addr=%h, want 12 3 8000000c",
                     bus.cycle_cnt, bus.instret, bus.imem_addr);
        end
    endtask

    task test_jump_slow;
        do_reset();
        run_instr(3, 2, 1'b1, 64'h8000_0101, $urandom);
        tests_run++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h8000_0100) begin
            tests_failed++;
            $display("FAIL jump_slow: req=%b addr=%h, want 1 80000100", bus.imem_req, bus.imem_addr);
        end
    endtask

    task test_pc_wrap;
        do_reset();
        run_instr(0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, $urandom);
        run_instr(1, 0, 1'b0, 64'd0, $urandom);
        tests_run++;
        if (bus.imem_addr !== 64'd0) begin
            tests_failed++;
            $display("FAIL pc_wrap: addr=%h, want 0", bus.imem_addr);
        end
    endtask

    task test_random;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 1'($urandom),
                      {$urandom, $urandom}, $urandom);
        end
        tests_run++;
        if (bus.instret !== 64'd40 || bus.err !== 1'b0 || bus.halted !== 1'b0) begin
            tests_failed++;
            $display("FAIL random_end: instret=%0d err=%b halted=%b, want 40 0 0", bus.instret, bus.err, bus.halted);
        end
    endtask

    task test_ebreak;
        int bad;
        do_reset();
        run_instr(1, 0, 1'b0, 64'd0, $urandom);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0010_0073;
        @(negedge clk);
        m_cycles++;
        bus.imem_ack = 1'b0;
        bus.halt_req = 1'b1;
        @(negedge clk);
        m_cycles++;
        m_instret++;
        bus.halt_req = 1'b0;
        tests_run++;
        if (bus.halted !== 1'b1 || bus.err !== 1'b0 || bus.imem_req !== 1'b0 || bus.wen_rd !== 1'b0 ||
            bus.inst_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL ebreak_flags: halted=%b err=%b req=%b wen=%b valid=%b, want 1 0 0 0 0",
                     bus.halted, bus.err, bus.imem_req, bus.wen_rd, bus.inst_valid);
        end
        tests_run++;
        if (bus.instret !== m_instret || bus.pc !== m_pc || bus.cycle_cnt !== m_cycles) begin
            tests_failed++;
            $display("FAIL ebreak_state: instret=%0d pc=%h cyc=%0d, want %0d %h %0d",
                     bus.instret, bus.pc, bus.cycle_cnt, m_instret, m_pc, m_cycles);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            bus.imem_ack = 1'($urandom);
            bus.ex_done  = 1'($urandom);
            bus.halt_req = 1'($urandom);
            @(negedge clk);
            if (bus.imem_req || bus.wen_rd || bus.ex_start || bus.cycle_cnt !== m_cycles ||
                bus.instret !== m_instret) bad++;
        end
        idle_inputs();
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL ebreak_frozen: %0d bad halt cycles, want 0", bad);
        end
    endtask

    task test_timeout;
        do_reset();
        for (int k = 0; k <= int'(TMO); k++) begin
            tests_run++;
            if (bus.imem_req !== 1'b1 || bus.err !== 1'b0) begin
                tests_failed++;
                $display("FAIL timeout_wait: cycle %0d req=%b err=%b, want 1 0", k, bus.imem_req, bus.err);
            end
            bus.imem_ack = 1'b0;
            @(negedge clk);
            m_cycles++;
        end
        tests_run++;
        if (bus.err !== 1'b1 || bus.halted !== 1'b1 || bus.pc !== RESET_PC || bus.imem_req !== 1'b0 ||
            bus.cycle_cnt !== m_cycles) begin
            tests_failed++;
            $display("FAIL timeout_halt: err=%b halted=%b pc=%h req=%b cyc=%0d, want 1 1 %h 0 %0d",
                     bus.err, bus.halted, bus.pc, bus.imem_req, bus.cycle_cnt, RESET_PC, m_cycles);
        end
        bus.imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        bus.imem_ack = 1'b0;
        tests_run++;
        if (bus.halted !== 1'b1 || bus.inst_valid !== 1'b0 || bus.cycle_cnt !== m_cycles) begin
            tests_failed++;
            $display("FAIL timeout_sticky: halted=%b valid=%b cyc=%0d, want 1 0 %0d",
                     bus.halted, bus.inst_valid, bus.cycle_cnt, m_cycles);
        end
    endtask

    task test_timeout_ack_edge;
        do_reset();
        run_instr(int'(TMO), 1, 1'b0, 64'd0, $urandom);
        tests_run++;
        if (bus.err !== 1'b0 || bus.halted !== 1'b0 || bus.imem_addr !== RESET_PC + 64'd4) begin
            tests_failed++;
            $display("FAIL timeout_ack_edge: err=%b halted=%b addr=%h, want 0 0 %h",
                     bus.err, bus.halted, bus.imem_addr, RESET_PC + 64'd4);
        end
    endtask

    task test_reset_mid_exec;
        do_reset();
        run_instr(0, 0, 1'b0, 64'd0, $urandom);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = $urandom;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst          = 1'b1;
        bus.ex_done  = 1'b1;
        bus.jump     = 1'b1;
        bus.jump_target = 64'h1234;
        #1;
        tests_run++;
        if (bus.pc !== RESET_PC || bus.imem_req !== 1'b0 || bus.inst !== 32'd0 || bus.inst_valid !== 1'b0 ||
            bus.ex_start !== 1'b0 || bus.wen_rd !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_exec: pc=%h req=%b inst=%h valid=%b start=%b wen=%b",
                     bus.pc, bus.imem_req, bus.inst, bus.inst_valid, bus.ex_start, bus.wen_rd);
        end
        tests_run++;
        if (bus.cycle_cnt !== 64'd0 || bus.instret !== 64'd0 || bus.halted !== 1'b0 || bus.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_exec_cnt: cyc=%0d ret=%0d halted=%b err=%b, want all 0",
                     bus.cycle_cnt, bus.instret, bus.halted, bus.err);
        end
        @(negedge clk);
        tests_run++;
        if (bus.wen_rd !== 1'b0 || bus.inst_valid !== 1'b0 || bus.pc !== RESET_PC) begin
            tests_failed++;
            $display("FAIL rst_hold: wen=%b valid=%b pc=%h, want 0 0 %h", bus.wen_rd, bus.inst_valid, bus.pc, RESET_PC);
        end
        idle_inputs();
        rst = 1'b0;
        #1;
        m_pc      = RESET_PC;
        m_cycles  = 64'd0;
        m_instret = 64'd0;
        run_instr(2, 1, 1'b0, 64'd0, $urandom);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_straight_line();
        test_jump_slow();
        test_pc_wrap();
        test_random();
        test_ebreak();
        test_timeout();
        test_timeout_ack_edge();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ysyx_22040365_ctrl.md
# ysyx_22040365_ctrl

Multi-cycle instruction sequencer for the ysyx_22040365 core. It owns the PC and steps each instruction through fetch, decode, execute and writeback: a req/ack handshake to instruction memory, then a start/done handshake to the execute unit, then a one-cycle regfile write strobe. It sits between instruction memory and the id/regfile/ex datapath, replacing the free-running `inst` input. It also provides halt-on-ebreak, a fetch timeout, and cycle/retired-instruction counters.

## Interface
- RESET_PC, 64'h8000_0000, PC value loaded on reset
- TIMEOUT, 8'd255, max cycles FETCH waits for imem_ack before error halt
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  64  fetch address (= pc)
- imem_ack  in  1  fetch complete, rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- inst  out  32  latched instruction to decoder
- inst_valid  out  1  high in DECODE, EXEC, WB
- ex_start  out  1  one-cycle pulse, first EXEC cycle
- ex_done  in  1  execute result valid
- jump  in  1  redirect, sampled with ex_done
- jump_target  in  64  redirect address, sampled with ex_done
- halt_req  in  1  decoded ebreak, sampled in DECODE
- wen_rd  out  1  regfile write strobe, one cycle in WB
- pc  out  64  address of current instruction
- halted  out  1  sticky halt flag
- err  out  1  sticky, set on fetch timeout
- cycle_cnt  out  64  cycles since reset, excluding HALT
- instret  out  64  retired instructions

## Operation
- States: FETCH, DECODE, EXEC, WB, HALT. Reset state is FETCH.
- FETCH:
  - imem_req=1 and imem_addr=pc, stable until ack.
  - On imem_ack: inst<=imem_rdata, go to DECODE.
  - Wait counter clears on entry and increments each cycle without ack. When it equals TIMEOUT with no ack: go to HALT with err<=1, halted<=1.
- DECODE: one cycle.
  - If halt_req=1: instret+1, halted<=1, go to HALT. No wen_rd, pc unchanged.
  - Otherwise go to EXEC.
- EXEC:
  - ex_start=1 only in the first cycle.
  - ex_done may arrive in that same cycle (single-cycle ex) or any later cycle.
  - On ex_done: pc_nxt <= jump ? {jump_target[63:1],1'b0} : pc+4 (64-bit wrap), then go to WB.
  - jump is ignored when ex_done=0.
- WB: one cycle.
  - wen_rd=1, pc<=pc_nxt, instret+1, go to FETCH.
- HALT: absorbing.
  - All strobes are 0. imem_req=0. Counters are frozen. Only rst exits.
- Counters: 64-bit and wrap naturally.
  - cycle_cnt increments in every non-HALT state.
  - instret increments on WB exit and on an ebreak in DECODE.

## Timing
- Reset values (asserted asynchronously):
  - state=FETCH, pc=RESET_PC, inst=0.
  - imem_req=0 during rst, 1 in the first cycle after release.
  - All strobes, counters, halted and err are 0.
- Minimum instruction latency is 4 cycles: ack in cycle 0 of FETCH, then DECODE, EXEC with ex_done in the same cycle, then WB.
- The next imem_req rises the cycle after WB, with the updated pc.
- ex_start never re-pulses while waiting for ex_done.
- Simultaneous imem_ack and timeout (counter==TIMEOUT): ack wins, no error.
- rst mid-operation: all outputs return to reset values immediately.
  - In-flight ack or done is discarded.
  - No wen_rd is issued for the interrupted instruction.
- imem_addr is always 4-byte aligned unless jump_target[1]=1. Bit 1 is passed through and bit 0 is forced to 0.

## Test plan
- Straight-line: ack in the first FETCH cycle, ex_done coincident with ex_start, 3 instructions.
  - pc goes 0x8000_0000 → 0x8000_0004 → 0x8000_0008.
  - wen_rd pulses every 4 cycles; instret=3, cycle_cnt=12.
- Jump with slow memory: ack after 3 wait cycles, ex_done 2 cycles after ex_start, jump=1, jump_target=0x8000_0101.
  - Next imem_addr=0x8000_0100.
  - Exactly one wen_rd pulse and one ex_start pulse.
- Ebreak: halt_req=1 in DECODE.
  - halted=1, no wen_rd, instret=1, imem_req=0.
  - cycle_cnt is frozen for 20 further cycles.
- Timeout with TIMEOUT=4: never ack.
  - err=1 and halted=1 after the fifth FETCH cycle; pc unchanged.
  - Repeat with ack on exactly that cycle: no error.
- Reset mid-EXEC: assert rst between clock edges while waiting for ex_done.
  - Outputs are immediately at reset values; pc=RESET_PC; no wen_rd.
  - Fetch restarts after release.
